mul_seq24: RTL and testbench
============================

Name: mul_seq24

Overview:
- Sequential 24x24 shift-add multiplier; multi-cycle replacement for the combinational multiplier between the register-file read ports and MulReg.
- Operands come from readData1/readData2.
- Delivers a 48-bit product and a one-cycle write strobe that drives MulReg's write enable directly.
- Supports unsigned and two's-complement signed operation; the control unit stalls the PC while Busy is high.

Parameters:
WIDTH, 24, operand width in bits; product is 2*WIDTH bits
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
Clock  input  1  system clock, rising-edge active
Reset  input  1  asynchronous, active-high reset
Start  input  1  request to begin a multiply; sampled on the rising edge
Signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with Start
A  input  WIDTH  multiplicand (readData1)
B  input  WIDTH  multiplier (readData2)
Busy  output  1  high while an operation is in progress
Done  output  1  one-cycle pulse; Product is valid
MulRegWrite  output  1  write strobe to MulReg; identical timing to Done
Product  output  2*WIDTH  result; held until the next accepted Start

Behaviour:
- Clock is the only clock. Reset is asynchronous and active-high.
- While Reset is high: state=IDLE; counter=0; accumulator, operand registers and Product=0; Busy=Done=MulRegWrite=0. These values take effect immediately, not at the next edge.
- States: IDLE, RUN, DONE.
- IDLE:
  - Start=1 at edge: latch operands; counter=0; go to RUN.
  - Otherwise stay in IDLE.
- Operand latch (Signed=1):
  - Store |A| and |B| as WIDTH-bit unsigned values.
  - Store neg_flag = A[WIDTH-1] XOR B[WIDTH-1].
  - |-2^(WIDTH-1)| = 2^(WIDTH-1) fits unsigned; no special case.
- Operand latch (Signed=0): store A and B unchanged; neg_flag=0.
- Operands are latched only on acceptance. Changes to A, B and Signed during RUN have no effect.
- RUN:
  - Each cycle processes one multiplier bit, LSB first: if the current bit is 1, add the shifted multiplicand into the 2*WIDTH-bit accumulator.
  - Counter increments each cycle.
  - At the edge that completes iteration WIDTH-1: go to DONE. Product = accumulator, or its two's-complement negation if neg_flag=1.
  - Product is never updated during RUN; it keeps the previous result.
- Latency: Start accepted at edge 0; Done high in the cycle following edge WIDTH (24 cycles for the default).
- DONE lasts exactly one cycle: Done=MulRegWrite=1, Busy=0.
  - Start=1 at the DONE edge is accepted (back-to-back): latch operands and go to RUN. Done still deasserts.
  - Otherwise go to IDLE.
- Busy=1 exactly while in RUN.
- Start while in RUN is ignored; no queuing.
- Product width is 2*WIDTH, so no overflow is possible. Signed range: -2^(2W-2)+2^(W-1) .. 2^(2W-2).
- Zero operands take the full WIDTH cycles; there is no early termination.
- Reset during RUN aborts the operation: no Done, no MulRegWrite, Product=0.
- Done and MulRegWrite are registered outputs, glitch-free.

Test Plan:
- Unsigned: Reset pulse, then Start with A=0x000003, B=0x000005, Signed=0 -> Busy high for 24 cycles; Done and MulRegWrite high for 1 cycle; Product=0x00000000000F.
- Unsigned max: A=B=0xFFFFFF, Signed=0 -> Product=0xFFFFFE000001. Same operands with Signed=1 (-1 x -1) -> Product=0x000000000001.
- Signed mixed signs: A=0xFFFFFF (-1), B=0x000007, Signed=1 -> Product=0xFFFFFFFFFFF9. Then A=0x800000, B=0x800000, Signed=1 -> Product=0x400000000000.
- Start during Busy: at RUN cycle 5, pulse Start with new operands -> ignored. Done still arrives at cycle 24 with the original result. Product is unchanged during RUN.
- Back-to-back: Start held high across the DONE cycle with A=2, B=3 -> the first result is written with MulRegWrite. The second operation starts with no IDLE cycle; Done 24 cycles later with Product=0x000000000006.
- Reset mid-operation: assert Reset asynchronously at RUN cycle 10 -> Busy, Done and Product go to 0 immediately. After release, no Done pulse appears. A fresh Start with A=4, B=4 -> Product=0x000000000010 after 24 cycles.

Source files
------------

// File: rtl/mul_seq24_if.sv
// mul_seq24_if: request/result bundle for the sequential multiplier.
//   master (control unit / bench): drives Start, Signed, A, B; sees Busy, Done,
//                                  MulRegWrite, Product
//   slave  (mul_seq24)           : the reverse
interface mul_seq24_if #(
    parameter int WIDTH = 24
);
    logic                 Start;
    logic                 Signed;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 Busy;
    logic                 Done;
    logic                 MulRegWrite;
    logic [2*WIDTH-1:0]   Product;

    modport master (
        output Start, Signed, A, B,
        input  Busy, Done, MulRegWrite, Product
    );

    modport slave (
        input  Start, Signed, A, B,
        output Busy, Done, MulRegWrite, Product
    );
endinterface

// File: rtl/mul_seq24.sv
// mul_seq24: sequential WIDTH x WIDTH shift-add multiplier, one multiplier bit
// per cycle, LSB first. Signed operands are multiplied as magnitudes and the
// result is negated at the end when the operand signs differ.
// Ports:
//   Clock - system clock, rising edge
//   Reset - asynchronous, active-high
//   bus   - mul_seq24_if slave: Start/Signed/A/B in; Busy/Done/MulRegWrite/Product out
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for Start
// RUN   | one multiplier bit per cycle, Busy=1
// DONE  | single cycle, Done=MulRegWrite=1, Product valid; Start accepted
module mul_seq24 #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 5
) (
    input  logic         Clock,
    input  logic         Reset,
    mul_seq24_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic                 neg_flag;
    logic [2*WIDTH-1:0]   product_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 mrw_q;

    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [2*WIDTH-1:0]   acc_sum;
    logic                 accept;

    // Magnitude of the most negative value is 2^(WIDTH-1), which still fits
    // as an unsigned WIDTH-bit number, so plain negation is enough.
    assign abs_a   = (bus.Signed && bus.A[WIDTH-1]) ? (~bus.A + WIDTH'(1)) : bus.A;
    assign abs_b   = (bus.Signed && bus.B[WIDTH-1]) ? (~bus.B + WIDTH'(1)) : bus.B;
    assign acc_sum = acc + (mplier[0] ? mcand : '0);
    assign accept  = bus.Start && (state != RUN);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            neg_flag  <= 1'b0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mrw_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            mrw_q  <= 1'b0;
            if (accept) begin
                state    <= RUN;
                cnt      <= '0;
                acc      <= '0;
                mcand    <= {{WIDTH{1'b0}}, abs_a};
                mplier   <= abs_b;
                neg_flag <= bus.Signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                busy_q   <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        acc    <= acc_sum;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state     <= DONE;
                            product_q <= neg_flag ? (~acc_sum + (2*WIDTH)'(1)) : acc_sum;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            mrw_q     <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;
    assign bus.MulRegWrite = mrw_q;
    assign bus.Product     = product_q;
endmodule

// File: tb/tb_mul_seq24.sv
module tb_mul_seq24;
    localparam int W = 24;

    logic Clock;
    logic Reset;
    int   n_total  = 0;
    int   n_passed = 0;

    mul_seq24_if #(.WIDTH(W)) bus ();

    mul_seq24 #(.WIDTH(W), .CNT_W(5)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference: plain integer multiplication of the operands as interpreted
    // by the Signed flag, truncated to the product width.
    function automatic logic [2*W-1:0] ref_mul(logic [W-1:0] a, logic [W-1:0] b, logic s);
        longint ia, ib, p;
        if (s) begin
            ia = longint'($signed(a));
            ib = longint'($signed(b));
        end else begin
            ia = longint'({40'd0, a});
            ib = longint'({40'd0, b});
        end
        p = ia * ib;
        return p[2*W-1:0];
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drives a request; returns at #1 after the accepting edge.
    task automatic start_op(logic [W-1:0] a, logic [W-1:0] b, logic s);
        bus.A      = a;
        bus.B      = b;
        bus.Signed = s;
        bus.Start  = 1'b1;
        @(posedge Clock); #1;
        bus.Start  = 1'b0;
        chk("busy_after_accept", 64'(bus.Busy), 64'd1);
    endtask

    // Waits for Done (bounded), checking Product is held during RUN, then
    // checks latency and the result cycle.
    task automatic wait_done(string tag, logic [2*W-1:0] exp_p, logic [2*W-1:0] prev_p, int exp_lat);
        int  cyc;
        bit  prod_held;
        cyc = 0;
        prod_held = 1'b1;
        while (cyc < 60) begin
            @(posedge Clock); #1;
            cyc++;
            if (bus.Done === 1'b1) break;
            if (bus.Product !== prev_p) prod_held = 1'b0;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_product_held"}, 64'(prod_held), 64'd1);
        chk({tag, "_done"}, 64'(bus.Done), 64'd1);
        chk({tag, "_mrw"}, 64'(bus.MulRegWrite), 64'd1);
        chk({tag, "_busy_low"}, 64'(bus.Busy), 64'd0);
        chk({tag, "_product"}, 64'(bus.Product), 64'(exp_p));
    endtask

    task automatic idle_check(string tag, logic [2*W-1:0] exp_p);
        @(posedge Clock); #1;
        chk({tag, "_done_1cyc"}, 64'(bus.Done), 64'd0);
        chk({tag, "_mrw_1cyc"}, 64'(bus.MulRegWrite), 64'd0);
        chk({tag, "_idle_busy"}, 64'(bus.Busy), 64'd0);
        chk({tag, "_product_kept"}, 64'(bus.Product), 64'(exp_p));
    endtask

    initial begin
        logic [2*W-1:0] last_p;
        logic [2*W-1:0] exp_p;
        logic [W-1:0]   ra, rb;
        logic           rs;
        int             done_seen;

        Reset      = 1'b0;
        bus.Start  = 1'b0;
        bus.Signed = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        #2 Reset = 1'b1;
        #1;
        chk("rst_busy", 64'(bus.Busy), 64'd0);
        chk("rst_done", 64'(bus.Done), 64'd0);
        chk("rst_mrw", 64'(bus.MulRegWrite), 64'd0);
        chk("rst_product", 64'(bus.Product), 64'd0);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);

        start_op(24'h000003, 24'h000005, 1'b0);
        wait_done("u3x5", 48'h00000000000F, 48'h0, 24);
        idle_check("u3x5", 48'h00000000000F);
        last_p = 48'h00000000000F;

        start_op(24'hFFFFFF, 24'hFFFFFF, 1'b0);
        wait_done("umax", 48'hFFFFFE000001, last_p, 24);
        last_p = 48'hFFFFFE000001;

        start_op(24'hFFFFFF, 24'hFFFFFF, 1'b1);
        wait_done("sm1m1", 48'h000000000001, last_p, 24);
        last_p = 48'h000000000001;

        start_op(24'hFFFFFF, 24'h000007, 1'b1);
        wait_done("sm1x7", 48'hFFFFFFFFFFF9, last_p, 24);
        last_p = 48'hFFFFFFFFFFF9;

        start_op(24'h800000, 24'h800000, 1'b1);
        wait_done("smin2", 48'h400000000000, last_p, 24);
        idle_check("smin2", 48'h400000000000);
        last_p = 48'h400000000000;

        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (i == 2) ra = '0;
            exp_p = ref_mul(ra, rb, rs);
            start_op(ra, rb, rs);
            wait_done($sformatf("rnd%0d", i), exp_p, last_p, 24);
            last_p = exp_p;
        end

        // Start during RUN is ignored and operand changes have no effect.
        ra = 24'h123456;
        rb = 24'hFEDCBA;
        exp_p = ref_mul(ra, rb, 1'b1);
        start_op(ra, rb, 1'b1);
        repeat (4) begin
            @(posedge Clock); #1;
        end
        bus.A      = 24'h000002;
        bus.B      = 24'h000002;
        bus.Signed = 1'b0;
        bus.Start  = 1'b1;
        @(posedge Clock); #1;
        bus.Start  = 1'b0;
        wait_done("ignore", exp_p, last_p, 19);
        last_p = exp_p;

        // Back-to-back: Start high during the DONE cycle.
        start_op(24'h00ABCD, 24'h000100, 1'b0);
        wait_done("b2b_first", 48'h000000ABCD00, last_p, 24);
        start_op(24'h000002, 24'h000003, 1'b0);
        chk("b2b_done_drop", 64'(bus.Done), 64'd0);
        wait_done("b2b_second", 48'h000000000006, 48'h000000ABCD00, 24);
        last_p = 48'h000000000006;

        // Reset during RUN cycle 10.
        start_op(24'h00F00F, 24'h0F0F0F, 1'b0);
        repeat (9) begin
            @(posedge Clock); #1;
        end
        #2 Reset = 1'b1;
        #1;
        chk("midrst_busy", 64'(bus.Busy), 64'd0);
        chk("midrst_done", 64'(bus.Done), 64'd0);
        chk("midrst_product", 64'(bus.Product), 64'd0);
        @(negedge Clock);
        Reset = 1'b0;
        done_seen = 0;
        repeat (30) begin
            @(posedge Clock); #1;
            if (bus.Done !== 1'b0 || bus.MulRegWrite !== 1'b0) done_seen++;
        end
        chk("midrst_no_done", 64'(done_seen), 64'd0);
        start_op(24'h000004, 24'h000004, 1'b0);
        wait_done("after_rst", 48'h000000000010, 48'h0, 24);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end
endmodule
